// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU bus to synchronous RAM / asynchronous ROM controller with
// parametrised address decode, per-region wait states and READY/ERR handshake.
module mem_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned ROM_BASE = 'h0000,
    parameter int unsigned ROM_AW   = 13,
    parameter int unsigned RAM_BASE = 'h2000,
    parameter int unsigned RAM_AW   = 14,
    parameter int unsigned ROM_WAIT = 0,
    parameter int unsigned RAM_WAIT = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [ADDR_W-1:0]    ADDR,
    input  logic [DATA_W-1:0]    DIN,
    output logic [DATA_W-1:0]    DOUT,
    input  logic                 RDN,
    input  logic [DATA_W/8-1:0]  WRN,
    output logic                 READY,
    output logic                 ERR,
    output logic [RAM_AW-1:0]    RAM_ADDR,
    output logic [DATA_W-1:0]    RAM_DIN,
    input  logic [DATA_W-1:0]    RAM_Q,
    output logic                 RAM_CE,
    output logic                 RAM_WE,
    output logic [DATA_W/8-1:0]  RAM_BE,
    output logic [ROM_AW-1:0]    ROM_ADDR,
    input  logic [DATA_W-1:0]    ROM_Q
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned EXT_W = ADDR_W + 1;

    // Region bounds in one extra bit so base + size never wraps.
    localparam logic [EXT_W-1:0] ROM_LO = EXT_W'(ROM_BASE);
    localparam logic [EXT_W-1:0] ROM_HI = EXT_W'(ROM_BASE) + EXT_W'(64'(1) << ROM_AW);
    localparam logic [EXT_W-1:0] RAM_LO = EXT_W'(RAM_BASE);
    localparam logic [EXT_W-1:0] RAM_HI = EXT_W'(RAM_BASE) + EXT_W'(64'(1) << RAM_AW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP,
        S_DONE,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        RG_NONE,
        RG_ROM,
        RG_RAM
    } region_t;

    state_t                r_state;
    state_t                w_next_state;

    region_t               r_region;
    logic                  r_rd;
    logic                  r_err;
    logic [BYTES-1:0]      r_wrn;
    logic [DATA_W-1:0]     r_din;
    logic [ROM_AW-1:0]     r_rom_loc;
    logic [RAM_AW-1:0]     r_ram_loc;
    logic [CNT_W-1:0]      r_cnt;

    logic [DATA_W-1:0]     r_dout;
    logic                  r_ready;
    logic                  r_err_out;
    logic [RAM_AW-1:0]     r_ram_addr;
    logic [DATA_W-1:0]     r_ram_din;
    logic                  r_ram_ce;
    logic                  r_ram_we;
    logic [BYTES-1:0]      r_ram_be;
    logic [ROM_AW-1:0]     r_rom_addr;

    logic [EXT_W-1:0]      w_addr_ext;
    logic                  w_in_rom;
    logic                  w_in_ram;
    region_t               w_dec_region;
    logic                  w_rd;
    logic                  w_wr_any;
    logic                  w_start;
    logic                  w_release;
    logic                  w_dec_err;
    logic [CNT_W-1:0]      w_dec_wait;
    logic [ROM_AW-1:0]     w_rom_loc;
    logic [RAM_AW-1:0]     w_ram_loc;

    region_t               w_acc_region;
    logic                  w_acc_rd;
    logic [BYTES-1:0]      w_acc_wrn;
    logic [DATA_W-1:0]     w_acc_din;
    logic [ROM_AW-1:0]     w_acc_rom_loc;
    logic [RAM_AW-1:0]     w_acc_ram_loc;
    logic                  w_enter_acc;

    // Address decode and access classification of the live bus.
    always_comb begin
        w_addr_ext   = EXT_W'(ADDR);
        w_in_rom     = (w_addr_ext >= ROM_LO) && (w_addr_ext < ROM_HI);
        w_in_ram     = (w_addr_ext >= RAM_LO) && (w_addr_ext < RAM_HI);
        w_dec_region = RG_NONE;
        if (w_in_rom) begin
            w_dec_region = RG_ROM;
        end else if (w_in_ram) begin
            w_dec_region = RG_RAM;
        end
        w_rd       = ~RDN;
        w_wr_any   = (WRN != {BYTES{1'b1}});
        w_start    = w_rd || w_wr_any;
        w_release  = RDN && (WRN == {BYTES{1'b1}});
        w_dec_err  = (w_dec_region == RG_NONE) || (w_rd && w_wr_any) ||
                     (!w_rd && (w_dec_region == RG_ROM));
        w_dec_wait = CNT_W'(0);
        if (w_dec_region == RG_ROM) begin
            w_dec_wait = CNT_W'(ROM_WAIT);
        end else if (w_dec_region == RG_RAM) begin
            w_dec_wait = CNT_W'(RAM_WAIT);
        end
        w_rom_loc  = ROM_AW'(ADDR - ADDR_W'(ROM_BASE));
        w_ram_loc  = RAM_AW'(ADDR - ADDR_W'(RAM_BASE));
    end

    // Access attributes: live decode when leaving IDLE, captured copy otherwise.
    always_comb begin
        w_acc_region  = r_region;
        w_acc_rd      = r_rd;
        w_acc_wrn     = r_wrn;
        w_acc_din     = r_din;
        w_acc_rom_loc = r_rom_loc;
        w_acc_ram_loc = r_ram_loc;
        if (r_state == S_IDLE) begin
            w_acc_region  = w_dec_region;
            w_acc_rd      = w_rd;
            w_acc_wrn     = WRN;
            w_acc_din     = DIN;
            w_acc_rom_loc = w_rom_loc;
            w_acc_ram_loc = w_ram_loc;
        end
        w_enter_acc = (w_next_state == S_ACCESS);
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if ((w_dec_region != RG_NONE) && (w_dec_wait != CNT_W'(0))) begin
                        w_next_state = S_WAIT;
                    end else begin
                        w_next_state = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: w_next_state = S_RESP;
            S_RESP:   w_next_state = S_DONE;
            S_DONE:   w_next_state = S_HOLD;
            S_HOLD: begin
                if (w_release) begin
                    w_next_state = S_IDLE;
                end
            end
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture at the start edge and wait-state countdown.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_region  <= RG_NONE;
            r_rd      <= 1'b0;
            r_err     <= 1'b0;
            r_wrn     <= {BYTES{1'b1}};
            r_din     <= '0;
            r_rom_loc <= '0;
            r_ram_loc <= '0;
            r_cnt     <= '0;
        end else if ((r_state == S_IDLE) && w_start) begin
            r_region  <= w_dec_region;
            r_rd      <= w_rd;
            r_err     <= w_dec_err;
            r_wrn     <= WRN;
            r_din     <= DIN;
            r_rom_loc <= w_rom_loc;
            r_ram_loc <= w_ram_loc;
            r_cnt     <= (w_dec_region == RG_NONE) ? CNT_W'(0) : w_dec_wait;
        end else if (r_state == S_WAIT) begin
            r_cnt     <= r_cnt - CNT_W'(1);
        end
    end

    // Memory-side strobes, registered so they are high exactly during ACCESS.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ram_ce   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_be   <= '0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_rom_addr <= '0;
        end else begin
            r_ram_ce <= w_enter_acc && (w_acc_region == RG_RAM);
            r_ram_we <= w_enter_acc && (w_acc_region == RG_RAM) && !w_acc_rd;
            r_ram_be <= '0;
            if (w_enter_acc && (w_acc_region == RG_RAM)) begin
                r_ram_addr <= w_acc_ram_loc;
                r_ram_be   <= w_acc_rd ? {BYTES{1'b1}} : ~w_acc_wrn;
                if (!w_acc_rd) begin
                    r_ram_din <= w_acc_din;
                end
            end
            if (w_enter_acc && (w_acc_region == RG_ROM)) begin
                r_rom_addr <= w_acc_rom_loc;
            end
        end
    end

    // Read data return and READY/ERR pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_dout    <= '0;
            r_ready   <= 1'b0;
            r_err_out <= 1'b0;
        end else begin
            r_ready   <= (w_next_state == S_DONE);
            r_err_out <= (w_next_state == S_DONE) && r_err;
            if ((r_state == S_RESP) && r_rd) begin
                case (r_region)
                    RG_RAM:  r_dout <= RAM_Q;
                    RG_ROM:  r_dout <= ROM_Q;
                    default: r_dout <= '0;
                endcase
            end
        end
    end

    assign DOUT     = r_dout;
    assign READY    = r_ready;
    assign ERR      = r_err_out;
    assign RAM_ADDR = r_ram_addr;
    assign RAM_DIN  = r_ram_din;
    assign RAM_CE   = r_ram_ce;
    assign RAM_WE   = r_ram_we;
    assign RAM_BE   = r_ram_be;
    assign ROM_ADDR = r_rom_addr;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against RAM/ROM models.
// dut0: ROM_WAIT=2, RAM_WAIT=0. dut1: RAM_WAIT=3.
module tb_mem_ctrl;

    logic        CLK;
    logic        RESET;
    logic [15:0] ADDR;
    logic [15:0] DIN;
    logic        RDN;
    logic [1:0]  WRN;
    logic        sel;

    int n_chk;
    int n_bad;

    // per-DUT signals
    logic        rdn0, rdn1;
    logic [1:0]  wrn0, wrn1;
    logic [15:0] dout0, dout1;
    logic        ready0, ready1, err0, err1;
    logic [13:0] ram_addr0, ram_addr1;
    logic [15:0] ram_din0, ram_din1, ram_q0, ram_q1;
    logic        ram_ce0, ram_ce1, ram_we0, ram_we1;
    logic [1:0]  ram_be0, ram_be1;
    logic [12:0] rom_addr0, rom_addr1;
    logic [15:0] rom_q0, rom_q1;

    logic [15:0] mem0 [0:16383];
    logic [15:0] mem1 [0:16383];

    // selected-DUT views
    logic        ready_s, err_s, ce_s, we_s;
    logic [15:0] dout_s, din_s;
    logic [13:0] raddr_s;
    logic [1:0]  be_s;

    // monitor state
    int          ce_cnt0, ce_cnt1, rdy_cnt0, rdy_cnt1;
    logic [13:0] last_addr;
    logic        last_we;
    logic [1:0]  last_be;
    logic [15:0] last_din;

    assign rdn0 = sel ? 1'b1  : RDN;
    assign wrn0 = sel ? 2'b11 : WRN;
    assign rdn1 = sel ? RDN   : 1'b1;
    assign wrn1 = sel ? WRN   : 2'b11;

    assign ready_s = sel ? ready1    : ready0;
    assign err_s   = sel ? err1      : err0;
    assign ce_s    = sel ? ram_ce1   : ram_ce0;
    assign we_s    = sel ? ram_we1   : ram_we0;
    assign dout_s  = sel ? dout1     : dout0;
    assign din_s   = sel ? ram_din1  : ram_din0;
    assign raddr_s = sel ? ram_addr1 : ram_addr0;
    assign be_s    = sel ? ram_be1   : ram_be0;

    function automatic logic [15:0] rom_word(input logic [12:0] a);
        return 16'hA500 ^ (16'(a) * 16'd3);
    endfunction

    assign rom_q0 = rom_word(rom_addr0);
    assign rom_q1 = rom_word(rom_addr1);

    mem_ctrl #(.ROM_WAIT(2), .RAM_WAIT(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN), .DOUT(dout0),
        .RDN(rdn0), .WRN(wrn0), .READY(ready0), .ERR(err0),
        .RAM_ADDR(ram_addr0), .RAM_DIN(ram_din0), .RAM_Q(ram_q0),
        .RAM_CE(ram_ce0), .RAM_WE(ram_we0), .RAM_BE(ram_be0),
        .ROM_ADDR(rom_addr0), .ROM_Q(rom_q0)
    );

    mem_ctrl #(.ROM_WAIT(0), .RAM_WAIT(3)) dut1 (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN), .DOUT(dout1),
        .RDN(rdn1), .WRN(wrn1), .READY(ready1), .ERR(err1),
        .RAM_ADDR(ram_addr1), .RAM_DIN(ram_din1), .RAM_Q(ram_q1),
        .RAM_CE(ram_ce1), .RAM_WE(ram_we1), .RAM_BE(ram_be1),
        .ROM_ADDR(rom_addr1), .ROM_Q(rom_q1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // synchronous RAM models with byte enables
    always @(posedge CLK) begin
        if (ram_ce0) begin
            if (ram_we0 && ram_be0[0]) mem0[ram_addr0][7:0]  <= ram_din0[7:0];
            if (ram_we0 && ram_be0[1]) mem0[ram_addr0][15:8] <= ram_din0[15:8];
            ram_q0 <= mem0[ram_addr0];
        end
        if (ram_ce1) begin
            if (ram_we1 && ram_be1[0]) mem1[ram_addr1][7:0]  <= ram_din1[7:0];
            if (ram_we1 && ram_be1[1]) mem1[ram_addr1][15:8] <= ram_din1[15:8];
            ram_q1 <= mem1[ram_addr1];
        end
    end

    // pulse counters and last RAM strobe snapshot, sampled mid-cycle
    always @(negedge CLK) begin
        if (ram_ce0) ce_cnt0  <= ce_cnt0 + 1;
        if (ram_ce1) ce_cnt1  <= ce_cnt1 + 1;
        if (ready0)  rdy_cnt0 <= rdy_cnt0 + 1;
        if (ready1)  rdy_cnt1 <= rdy_cnt1 + 1;
        if (ce_s) begin
            last_addr <= raddr_s;
            last_we   <= we_s;
            last_be   <= be_s;
            last_din  <= din_s;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bus cycle on the selected DUT; returns READY latency from E0.
    task automatic bus_op(input logic [15:0] a, input logic [15:0] d, input logic rd_n,
                          input logic [1:0] wr_n, input int hold,
                          output int lat, output logic [15:0] q, output logic e);
        @(negedge CLK);
        ADDR = a; DIN = d; RDN = rd_n; WRN = wr_n;
        @(posedge CLK);
        #1;
        ADDR = 16'hFFFF; DIN = 16'h0000;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            #1;
            if (ready_s) begin
                lat = i;
                break;
            end
        end
        q = dout_s;
        e = err_s;
        if (lat < 0) check_eq("ready_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        check_eq("ready_width", 32'(ready_s), 32'd0);
        repeat (hold) @(posedge CLK);
        @(negedge CLK);
        RDN = 1'b1; WRN = 2'b11;
        repeat (3) @(posedge CLK);
    endtask

    int          lat;
    logic [15:0] q;
    logic        e;
    int          ce_snap, rdy_snap;

    initial begin
        n_chk = 0; n_bad = 0;
        ce_cnt0 = 0; ce_cnt1 = 0; rdy_cnt0 = 0; rdy_cnt1 = 0;
        for (int i = 0; i < 16384; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        sel = 1'b0; ADDR = 16'h0; DIN = 16'h0; RDN = 1'b1; WRN = 2'b11;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_dout",  32'(dout0), 32'h0);
        check_eq("rst_ready", 32'(ready0), 32'h0);
        check_eq("rst_err",   32'(err0), 32'h0);
        check_eq("rst_ce",    32'({ram_ce0, ram_we0, ram_be0}), 32'h0);
        check_eq("rst_addr",  32'({ram_addr0, rom_addr0}), 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        // strobes high after reset: nothing starts
        ce_snap = ce_cnt0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check_eq("idle_no_ce", 32'(ce_cnt0 - ce_snap), 32'd0);

        // RAM word write then read
        ce_snap = ce_cnt0;
        bus_op(16'h2004, 16'hBEEF, 1'b1, 2'b00, 0, lat, q, e);
        check_eq("wr_lat",   32'(lat), 32'd2);
        check_eq("wr_err",   32'(e), 32'd0);
        check_eq("wr_ce1",   32'(ce_cnt0 - ce_snap), 32'd1);
        check_eq("wr_addr",  32'(last_addr), 32'h0004);
        check_eq("wr_we",    32'(last_we), 32'd1);
        check_eq("wr_be",    32'(last_be), 32'h3);
        check_eq("wr_din",   32'(last_din), 32'hBEEF);
        bus_op(16'h2004, 16'h0000, 1'b0, 2'b11, 0, lat, q, e);
        check_eq("rd_lat",   32'(lat), 32'd2);
        check_eq("rd_data",  32'(q), 32'hBEEF);
        check_eq("rd_err",   32'(e), 32'd0);
        check_eq("rd_we",    32'(last_we), 32'd0);
        check_eq("rd_be",    32'(last_be), 32'h3);

        // byte lane write
        bus_op(16'h2004, 16'h1234, 1'b1, 2'b10, 0, lat, q, e);
        check_eq("bl_be",    32'(last_be), 32'h1);
        bus_op(16'h2004, 16'h0000, 1'b0, 2'b11, 0, lat, q, e);
        check_eq("bl_data",  32'(q), 32'hBE34);

        // ROM read with two wait states
        ce_snap = ce_cnt0;
        bus_op(16'h0003, 16'h0000, 1'b0, 2'b11, 0, lat, q, e);
        check_eq("rom_lat",  32'(lat), 32'd4);
        check_eq("rom_data", 32'(q), 32'hA509);
        check_eq("rom_addr", 32'(rom_addr0), 32'h3);
        check_eq("rom_err",  32'(e), 32'd0);
        check_eq("rom_noce", 32'(ce_cnt0 - ce_snap), 32'd0);

        // ROM write: dropped with error, DOUT kept
        ce_snap = ce_cnt0;
        bus_op(16'h0010, 16'h5555, 1'b1, 2'b00, 0, lat, q, e);
        check_eq("romw_err",  32'(e), 32'd1);
        check_eq("romw_noce", 32'(ce_cnt0 - ce_snap), 32'd0);
        check_eq("romw_dout", 32'(q), 32'hA509);

        // unmapped read
        ce_snap = ce_cnt0;
        bus_op(16'h8000, 16'h0000, 1'b0, 2'b11, 0, lat, q, e);
        check_eq("um_lat",   32'(lat), 32'd2);
        check_eq("um_data",  32'(q), 32'h0);
        check_eq("um_err",   32'(e), 32'd1);
        check_eq("um_noce",  32'(ce_cnt0 - ce_snap), 32'd0);

        // read and write strobes together: read with error
        bus_op(16'h2000, 16'hFFFF, 1'b0, 2'b00, 0, lat, q, e);
        check_eq("both_err",  32'(e), 32'd1);
        check_eq("both_we",   32'(last_we), 32'd0);
        check_eq("both_addr", 32'(last_addr), 32'h0);
        check_eq("both_data", 32'(q), 32'h0);

        // strobes held after READY: single access, then IDLE again
        ce_snap = ce_cnt0;
        bus_op(16'h2004, 16'h0000, 1'b0, 2'b11, 10, lat, q, e);
        check_eq("hold_ce1",  32'(ce_cnt0 - ce_snap), 32'd1);
        bus_op(16'h2004, 16'h0000, 1'b0, 2'b11, 0, lat, q, e);
        check_eq("rel_lat",   32'(lat), 32'd2);
        check_eq("rel_data",  32'(q), 32'hBE34);

        // reset asserted mid-access clears everything at once
        @(negedge CLK);
        ADDR = 16'h2008; DIN = 16'h5555; RDN = 1'b1; WRN = 2'b00;
        @(posedge CLK);
        #2;
        check_eq("mid_ce_up", 32'(ram_ce0), 32'd1);
        RESET = 1'b1;
        #1;
        check_eq("mid_rst_ce",   32'({ram_ce0, ram_we0, ram_be0}), 32'h0);
        check_eq("mid_rst_dout", 32'(dout0), 32'h0);
        check_eq("mid_rst_addr", 32'(ram_addr0), 32'h0);
        RDN = 1'b1; WRN = 2'b11;
        @(negedge CLK);
        ce_snap = ce_cnt0; rdy_snap = rdy_cnt0;
        RESET = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        #1;
        check_eq("mid_no_ce",  32'(ce_cnt0 - ce_snap), 32'd0);
        check_eq("mid_no_rdy", 32'(rdy_cnt0 - rdy_snap), 32'd0);

        // dut1: reset while in WAIT, READY never pulses
        sel = 1'b1;
        @(negedge CLK);
        ADDR = 16'h2004; RDN = 1'b0; WRN = 2'b11;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        ce_snap = ce_cnt1; rdy_snap = rdy_cnt1;
        @(negedge CLK);
        RESET = 1'b1;
        RDN = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        #1;
        check_eq("wrst_no_rdy", 32'(rdy_cnt1 - rdy_snap), 32'd0);
        check_eq("wrst_no_ce",  32'(ce_cnt1 - ce_snap), 32'd0);

        // dut1 normal accesses with three RAM wait states
        bus_op(16'h2004, 16'hCAFE, 1'b1, 2'b00, 0, lat, q, e);
        check_eq("w3_wr_lat", 32'(lat), 32'd5);
        check_eq("w3_wr_err", 32'(e), 32'd0);
        check_eq("w3_wr_be",  32'(last_be), 32'h3);
        bus_op(16'h2004, 16'h0000, 1'b0, 2'b11, 0, lat, q, e);
        check_eq("w3_rd_lat",  32'(lat), 32'd5);
        check_eq("w3_rd_data", 32'(q), 32'hCAFE);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Parametrised synchronous memory controller between the CPU bus and one synchronous RAM plus one asynchronous ROM.
- Decodes each bus cycle into a RAM, ROM or unmapped region and inserts per-region wait states.
- Handshakes completion with READY, returns registered read data and flags illegal accesses on ERR.
- Generalises the fixed 16-bit RAM/ROM decoder: width, byte lanes, region bases/sizes and wait states are parameters.

Parameters:
- DATA_W, 16, data width; multiple of 8; BYTES = DATA_W/8.
- ADDR_W, 16, CPU address width.
- ROM_BASE, 'h0000, first ROM address.
- ROM_AW, 13, ROM size is 2^ROM_AW words.
- RAM_BASE, 'h2000, first RAM address; need not be size-aligned.
- RAM_AW, 14, RAM size is 2^RAM_AW words.
- ROM_WAIT, 0, extra wait cycles for ROM accesses (0..15).
- RAM_WAIT, 0, extra wait cycles for RAM accesses (0..15).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- ADDR  in  ADDR_W  CPU word address.
- DIN  in  DATA_W  CPU write data.
- DOUT  out  DATA_W  registered read data.
- RDN  in  1  read strobe, active low.
- WRN  in  BYTES  per-byte write strobes, active low; bit 0 = DIN[7:0].
- READY  out  1  one-cycle completion pulse.
- ERR  out  1  error flag, valid only while READY=1.
- RAM_ADDR  out  RAM_AW  RAM word address.
- RAM_DIN  out  DATA_W  RAM write data.
- RAM_Q  in  DATA_W  RAM read data, valid 1 cycle after the CE edge.
- RAM_CE  out  1  RAM clock enable.
- RAM_WE  out  1  RAM write enable.
- RAM_BE  out  BYTES  RAM byte enables; bit 0 = low byte.
- ROM_ADDR  out  ROM_AW  ROM word address.
- ROM_Q  in  DATA_W  ROM data, combinational from ROM_ADDR.

Behaviour:
- Reset (async, immediate):
  - State returns to IDLE; wait counter = 0.
  - DOUT, READY, ERR, RAM_CE, RAM_WE, RAM_BE, RAM_ADDR, RAM_DIN and ROM_ADDR all = 0.
  - A write interrupted by reset is not guaranteed to complete.
- Start condition: in IDLE, with RDN=0 or any WRN bit=0, sampled at the clock edge E0. At E0:
  - Capture ADDR, DIN and the strobes.
  - Decode the region and load the wait counter.
- Decode:
  - ROM if ROM_BASE <= ADDR < ROM_BASE + 2^ROM_AW.
  - Else RAM if RAM_BASE <= ADDR < RAM_BASE + 2^RAM_AW.
  - Else unmapped. ROM wins on overlap.
  - Local address = ADDR - region base, truncated to the region AW.
- Access type:
  - Read if RDN=0.
  - Write if RDN=1 and any WRN=0.
  - RDN=0 together with any WRN=0 is performed as a read, with ERR=1.
- States:
  - IDLE -> WAIT if the region's wait count W > 0; otherwise -> ACCESS. Unmapped accesses always go to ACCESS.
  - WAIT: counter decrements each edge; -> ACCESS on the edge where the counter = 1 (exactly W cycles in WAIT).
  - ACCESS (1 cycle), RAM: RAM_CE=1, RAM_ADDR = local address.
    - Read: RAM_BE all 1, RAM_WE=0.
    - Write: RAM_WE=1, RAM_BE = ~captured WRN, RAM_DIN = captured DIN.
  - ACCESS, ROM: ROM_ADDR = local address; RAM_CE stays 0.
  - ACCESS, unmapped: no memory signal is asserted.
  - RESP (1 cycle): on its closing edge, DOUT is loaded and READY<=1, ERR<=error.
    - RAM read: DOUT <= RAM_Q.
    - ROM read: DOUT <= ROM_Q.
    - Unmapped read: DOUT <= 0.
    - Writes leave DOUT unchanged.
  - DONE (1 cycle): READY=1. Then -> HOLD, with READY and ERR cleared.
  - HOLD: stays until RDN=1 and all WRN=1 at an edge, then -> IDLE. Held strobes never retrigger a second access.
- Latency: READY is high for exactly the cycle between edges E0+2+W and E0+3+W.
- ERR=1 (with READY only) for:
  - unmapped read or write;
  - write to ROM (dropped; RAM_CE stays 0);
  - read and write strobes asserted simultaneously.
- Memory strobes: RAM_CE and RAM_WE are decoded only from state registers (glitch-free) and are high only in ACCESS.
- Inputs may change after E0 without affecting the access in flight.

Test Plan:
1. Reset:
   - Assert RESET mid-cycle with strobes low -> all outputs 0 immediately.
   - Release RESET -> no access starts until the strobes have been seen low in IDLE.
2. RAM word write/read:
   - Write 0x2004 = 16'hBEEF with WRN=2'b00 -> RAM_ADDR=0x0004, RAM_WE=1, RAM_BE=2'b11 for one cycle.
   - READY at E0+2.
   - Read back -> DOUT=16'hBEEF, ERR=0.
3. Byte lane:
   - Write 0x2004 = 16'h1234 with WRN=2'b10 -> RAM_BE=2'b01.
   - Subsequent read -> 16'hBE34.
4. ROM read with ROM_WAIT=2:
   - Read 0x0003 -> ROM_ADDR=3.
   - DOUT = ROM word 3; READY at E0+4.
   - RAM_CE never high.
5. Errors:
   - Read 0x8000 -> DOUT=0, ERR=1.
   - Write 0x0010 -> ERR=1, no RAM_CE/RAM_WE.
   - RDN=0 with WRN=2'b00 at 0x2000 -> read performed, ERR=1.
6. Handshake and reset:
   - Hold RDN low for 10 cycles after READY -> exactly one RAM_CE pulse.
   - Release RDN -> IDLE.
   - RESET asserted in WAIT (RAM_WAIT=3) -> READY never pulses; next access proceeds normally.
